// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbiter sharing one register bank between two requesters
// Issues a one-cycle strobe, waits for ack with a bounded timeout, returns a done pulse to the granted port.
module reg_bank_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int REG_W       = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              ena,
   input  logic              req0_valid,
   input  logic              req0_wr_rdn,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [REG_W-1:0]  req0_wdata,
   output logic              req0_done,
   output logic [REG_W-1:0]  req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_wr_rdn,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [REG_W-1:0]  req1_wdata,
   output logic              req1_done,
   output logic [REG_W-1:0]  req1_rdata,
   output logic              req1_err,
   output logic              bank_wr_rdn,
   output logic [ADDR_W-1:0] bank_addr,
   output logic [REG_W-1:0]  bank_wdata,
   output logic              bank_we,
   input  logic [REG_W-1:0]  bank_rdata,
   input  logic              bank_ack,
   input  logic              bank_err,
   output logic              busy,
   output logic              gnt_id,
   output logic [7:0]        timeout_cnt
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              gnt_id_q, gnt_id_d;
   logic              bank_wr_rdn_q, bank_wr_rdn_d;
   logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
   logic [REG_W-1:0]  bank_wdata_q, bank_wdata_d;
   logic              bank_we_q, bank_we_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic              err0_q, err0_d, err1_q, err1_d;
   logic [REG_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [7:0]        timeout_cnt_q, timeout_cnt_d;

   logic              sel;
   logic              cpl, cpl_to;
   logic [REG_W-1:0]  cpl_rdata;
   logic              cpl_err;

   // On a tie the port that was not granted last time wins
   assign sel = (req0_valid && req1_valid) ? ~gnt_id_q : req1_valid;

   always_comb begin
      state_d       = state_q;
      gnt_id_d      = gnt_id_q;
      bank_wr_rdn_d = bank_wr_rdn_q;
      bank_addr_d   = bank_addr_q;
      bank_wdata_d  = bank_wdata_q;
      bank_we_d     = 1'b0;
      wait_cnt_d    = wait_cnt_q;
      done0_d       = 1'b0;
      done1_d       = 1'b0;
      err0_d        = err0_q;
      err1_d        = err1_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      timeout_cnt_d = timeout_cnt_q;
      cpl           = 1'b0;
      cpl_to        = 1'b0;
      cpl_rdata     = '0;
      cpl_err       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ena && (req0_valid || req1_valid)) begin
               gnt_id_d      = sel;
               bank_wr_rdn_d = sel ? req1_wr_rdn : req0_wr_rdn;
               bank_addr_d   = sel ? req1_addr   : req0_addr;
               bank_wdata_d  = sel ? req1_wdata  : req0_wdata;
               bank_we_d     = sel ? req1_wr_rdn : req0_wr_rdn;
               wait_cnt_d    = '0;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = CNT_W'(1);
            if (bank_ack) cpl = 1'b1;
            else          state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bank_ack) begin
               cpl = 1'b1;
            end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC)) begin
               cpl    = 1'b1;
               cpl_to = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Writes keep the port's previous read data; a timeout forces zero
      if (cpl) begin
         state_d = S_DONE;
         if (cpl_to)             cpl_rdata = '0;
         else if (bank_wr_rdn_q) cpl_rdata = gnt_id_q ? rdata1_q : rdata0_q;
         else                    cpl_rdata = bank_rdata;
         cpl_err = cpl_to ? 1'b1 : bank_err;
         if (gnt_id_q) begin
            done1_d  = 1'b1;
            rdata1_d = cpl_rdata;
            err1_d   = cpl_err;
         end else begin
            done0_d  = 1'b1;
            rdata0_d = cpl_rdata;
            err0_d   = cpl_err;
         end
         if (cpl_to && timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q       <= S_IDLE;
         gnt_id_q      <= 1'b1;
         bank_wr_rdn_q <= 1'b0;
         bank_addr_q   <= '0;
         bank_wdata_q  <= '0;
         bank_we_q     <= 1'b0;
         wait_cnt_q    <= '0;
         done0_q       <= 1'b0;
         done1_q       <= 1'b0;
         err0_q        <= 1'b0;
         err1_q        <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         timeout_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         gnt_id_q      <= gnt_id_d;
         bank_wr_rdn_q <= bank_wr_rdn_d;
         bank_addr_q   <= bank_addr_d;
         bank_wdata_q  <= bank_wdata_d;
         bank_we_q     <= bank_we_d;
         wait_cnt_q    <= wait_cnt_d;
         done0_q       <= done0_d;
         done1_q       <= done1_d;
         err0_q        <= err0_d;
         err1_q        <= err1_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign req0_done   = done0_q;
   assign req0_rdata  = rdata0_q;
   assign req0_err    = err0_q;
   assign req1_done   = done1_q;
   assign req1_rdata  = rdata1_q;
   assign req1_err    = err1_q;
   assign bank_wr_rdn = bank_wr_rdn_q;
   assign bank_addr   = bank_addr_q;
   assign bank_wdata  = bank_wdata_q;
   assign bank_we     = bank_we_q;
   assign busy        = (state_q != S_IDLE);
   assign gnt_id      = gnt_id_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

   logic       clk = 1'b0;
   logic       rstb;
   logic       ena;
   logic       req0_valid, req0_wr_rdn, req1_valid, req1_wr_rdn;
   logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
   logic       req0_done, req0_err, req1_done, req1_err;
   logic [7:0] req0_rdata, req1_rdata;
   logic       bank_wr_rdn, bank_we, bank_ack, bank_err;
   logic [7:0] bank_addr, bank_wdata, bank_rdata;
   logic       busy, gnt_id;
   logic [7:0] timeout_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reg_bank_arbiter #(.ADDR_W(8), .REG_W(8), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rstb(rstb), .ena(ena),
      .req0_valid(req0_valid), .req0_wr_rdn(req0_wr_rdn), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_wr_rdn(req1_wr_rdn), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
      .bank_wr_rdn(bank_wr_rdn), .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_we(bank_we),
      .bank_rdata(bank_rdata), .bank_ack(bank_ack), .bank_err(bank_err),
      .busy(busy), .gnt_id(gnt_id), .timeout_cnt(timeout_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_gnt"}, gnt_id, 1);
      check({tag, "_tcnt"}, timeout_cnt, 0);
      check({tag, "_we"}, bank_we, 0);
      check({tag, "_addr"}, bank_addr, 0);
      check({tag, "_wdata"}, bank_wdata, 0);
      check({tag, "_done"}, {req1_done, req0_done}, 0);
      check({tag, "_rdata"}, {req1_rdata, req0_rdata}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int hits;
      rstb = 1'b0; ena = 1'b1;
      req0_valid = 0; req0_wr_rdn = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 0; req1_wr_rdn = 0; req1_addr = 0; req1_wdata = 0;
      bank_ack = 1'b1; bank_err = 1'b0; bank_rdata = 8'h00;
      step(); step();
      check_reset("rst");
      rstb = 1'b1;
      step();

      // port 0 write, ack tied high
      req0_valid = 1; req0_wr_rdn = 1; req0_addr = 8'h12; req0_wdata = 8'hA5;
      step();
      check("w_we", bank_we, 1);
      check("w_addr", bank_addr, 8'h12);
      check("w_wdata", bank_wdata, 8'hA5);
      check("w_gnt", gnt_id, 0);
      check("w_early", req0_done, 0);
      step();
      check("w_done", req0_done, 1);
      check("w_err", req0_err, 0);
      check("w_we_off", bank_we, 0);
      req0_valid = 0;
      step();
      check("w_idle", {busy, req0_done}, 0);

      // port 1 read, ack 3 cycles after issue
      bank_ack = 0; bank_rdata = 8'h5C;
      req1_valid = 1; req1_wr_rdn = 0; req1_addr = 8'h34;
      step();
      check("r_issue", {bank_we, gnt_id, bank_addr}, {1'b0, 1'b1, 8'h34});
      step(); step();
      check("r_early", req1_done, 0);
      step();
      bank_ack = 1;
      check("r_early2", req1_done, 0);
      step();
      check("r_done", req1_done, 1);
      check("r_rdata", req1_rdata, 8'h5C);
      check("r_err", req1_err, 0);
      req1_valid = 0;
      step();

      // both ports continuously valid: grants alternate
      bank_rdata = 8'h77;
      req0_valid = 1; req0_wr_rdn = 0; req0_addr = 8'h40;
      req1_valid = 1; req1_wr_rdn = 0; req1_addr = 8'h41;
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         step();
         if (req0_done || req1_done) begin
            check($sformatf("alt_%0d", n), {req1_done, req0_done}, (n % 2) ? 2'b10 : 2'b01);
            n++;
         end
      end
      req0_valid = 0; req1_valid = 0;
      check("alt_count", n, 6);
      step();

      // timeout: ack held low
      bank_ack = 0;
      req0_valid = 1; req0_wr_rdn = 0; req0_addr = 8'h20;
      step();
      check("to_gnt", {busy, gnt_id}, 2'b10);
      hits = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (req0_done) hits++;
      end
      check("to_early", hits, 0);
      step();
      check("to_done", req0_done, 1);
      check("to_err", req0_err, 1);
      check("to_rdata", req0_rdata, 0);
      check("to_tcnt", timeout_cnt, 1);

      // valid kept high: repeated timeouts saturate the counter
      n = 0;
      for (int c = 0; c < 299 * 19 + 200 && n < 299; c++) begin
         step();
         if (req0_done) n++;
      end
      req0_valid = 0;
      check("sat_count", n, 299);
      check("sat_tcnt", timeout_cnt, 255);
      step();

      // ena low blocks the grant
      ena = 0; bank_ack = 1;
      req1_valid = 1; req1_wr_rdn = 0; req1_addr = 8'h55;
      hits = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (busy) hits++;
      end
      check("ena_block", hits, 0);
      ena = 1;
      step();
      check("ena_issue", {busy, gnt_id, bank_addr}, {1'b1, 1'b1, 8'h55});
      step();
      check("ena_done", req1_done, 1);
      check("ena_rdata", req1_rdata, 8'h77);
      req1_valid = 0;
      step();

      // reset in the middle of WAIT
      bank_ack = 0;
      req0_valid = 1; req0_wr_rdn = 1; req0_addr = 8'h66; req0_wdata = 8'h99;
      step(); step(); step();
      check("mid_busy", busy, 1);
      rstb = 0;
      #1;
      check_reset("mid");
      req0_valid = 0;
      step();
      rstb = 1;
      hits = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (req0_done || req1_done || busy) hits++;
      end
      check("mid_quiet", hits, 0);

      // ack on the timeout cycle wins
      bank_rdata = 8'h3C; bank_err = 0;
      req1_valid = 1; req1_wr_rdn = 0; req1_addr = 8'h70;
      step();
      hits = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (req1_done) hits++;
      end
      bank_ack = 1;
      check("edge_early", hits, 0);
      step();
      check("edge_done", req1_done, 1);
      check("edge_err", req1_err, 0);
      check("edge_rdata", req1_rdata, 8'h3C);
      check("edge_tcnt", timeout_cnt, 0);
      req1_valid = 0; bank_ack = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-port arbiter that shares the single-ported register bank between two requesters, typically the SPI peripheral (port 0) and an on-chip debug/sequencer master (port 1). It grants one access at a time using round-robin arbitration and drives the bank's application interface with a one-cycle strobe. It waits for the bank's acknowledge, with a bounded timeout, and returns read data and error status to the granted requester as a one-cycle completion pulse.

## Interface
Parameters:
- ADDR_W, 8, address width, matches the bank.
- REG_W, 8, data width, matches the bank.
- TIMEOUT_CYC, 16, maximum cycles to wait for bank_ack; must be ≥1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstb  in  1  asynchronous, active-low reset.
- ena  in  1  arbiter enable; low blocks new grants, and an in-flight access still completes.
- req0_valid / req1_valid  in  1  request pending; held high with stable fields until the matching done pulse.
- req0_wr_rdn / req1_wr_rdn  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  target address.
- req0_wdata / req1_wdata  in  REG_W  write data.
- req0_done / req1_done  out  1  one-cycle completion pulse.
- req0_rdata / req1_rdata  out  REG_W  read data; valid while done is high and held until the next completion to that port.
- req0_err / req1_err  out  1  error status; valid with done.
- bank_wr_rdn  out  1  access direction to the bank.
- bank_addr  out  ADDR_W  bank address.
- bank_wdata  out  REG_W  bank write data.
- bank_we  out  1  write strobe.
- bank_rdata  in  REG_W  bank read data.
- bank_ack  in  1  bank acknowledge.
- bank_err  in  1  bank error; sampled with ack.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  index of the last granted port.
- timeout_cnt  out  8  saturating count of timed-out accesses.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if ena=1 and any reqN_valid=1, select a port and go to ISSUE.
  - If only one port is valid, that port is selected.
  - If both are valid, the port ≠ gnt_id wins (round-robin).
  - On selection, latch wr_rdn, addr and wdata into bank_*, and set gnt_id.
- ISSUE: lasts one cycle. bank_we=1 only if the access is a write; the timeout counter is cleared on entry.
  - bank_ack=1 in this cycle: go to DONE.
  - Otherwise: go to WAIT.
- WAIT: sample bank_ack every cycle.
  - Ack seen: go to DONE.
  - Waited cycles (ISSUE plus WAIT) reach TIMEOUT_CYC without ack: go to DONE as a timeout.
- On ack: capture rdata = bank_rdata for reads and rdata unchanged for writes; capture err = bank_err.
- On timeout: capture rdata = 0 and err = 1; timeout_cnt increments, saturating at 255.
- DONE: lasts one cycle. req[gnt_id]_done=1 with the captured rdata and err; the next state is IDLE.
- bank_addr, bank_wdata and bank_wr_rdn hold their values from grant until the next grant.
- bank_we is 0 outside ISSUE.
- Requester rule: valid must drop in the cycle after done. If valid is still high in IDLE, it is treated as a new request.
- Changes to a requester's fields while it is not granted are ignored until grant.

## Timing
- Reset values: state = IDLE; all done, err, rdata, bank_* and busy outputs = 0; gnt_id = 1, so port 0 wins the first tie; timeout_cnt = 0.
- With bank_ack tied to 1:
  - Valid is seen in IDLE at cycle T.
  - ISSUE at T+1, with bank_we high for writes.
  - done is high during T+2.
  - The earliest next grant is evaluated in IDLE at T+3, giving a throughput of 1 access per 3 cycles.
- Ack latency L cycles after ISSUE: done is high at T+2+L.
- Timeout: done with err=1 is high exactly TIMEOUT_CYC+1 cycles after ISSUE entry.
- Ack arriving in the same cycle the timeout is reached: the ack wins, err = bank_err, and timeout_cnt is unchanged.
- ena falling during ISSUE or WAIT: the access completes normally, then the FSM stays in IDLE while ena=0.
- rstb asserted mid-access: immediate return to reset values; no done is issued, and the requester must re-request.
- Both valids rising in the same cycle as a DONE for port 0: the next grant goes to port 1.

## Test plan
- Reset, then port 0 write addr=0x12 wdata=0xA5 with ack tied 1:
  - bank_we is high for one cycle with addr 0x12 and wdata 0xA5.
  - req0_done is high 2 cycles after valid, with req0_err=0.
- Port 1 read addr=0x34 with the bank returning 0x5C and ack delayed 3 cycles: req1_done at T+5 with req1_rdata=0x5C and req1_err=0.
- Both ports continuously valid for 6 accesses: grants alternate 0,1,0,1,0,1; no port is granted twice in a row.
- bank_ack held 0 with TIMEOUT_CYC=16:
  - done at ISSUE+17 with err=1 and rdata=0; timeout_cnt=1.
  - 300 repeated timeouts saturate timeout_cnt at 255.
- Control cases:
  - ena=0 with valid high: no grant. Raising ena grants the request on the next cycle.
  - rstb pulsed low during WAIT: outputs return to their reset values and no done pulse appears.
  - Ack arriving on the timeout cycle with bank_err=0: err=0.
